status_reg: RTL and testbench

// 6502 processor status register (P), the consumer side of the ALU flag interface.
// - Captures N/V/Z/C from the ALU under per-flag write enables.
// - Executes the flag instructions: SEC/CLC/SEI/CLI/SED/CLD/CLV.
// - Loads P from the data bus for PLP/RTI and formats P for PHP/BRK/IRQ pushes.
// - Feeds carry-in and the decimal enable back to the ALU.
// - Supplies the interrupt mask to interrupt logic, with the 6502 one-instruction latency.

---
 rtl/status_reg.sv | 100 ++++++++++
 tb/tb_status_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/status_reg.sv
// 6502 processor status register (P): ALU flag capture, flag instructions,
// PLP/RTI load, push-image formatting and a delayed interrupt mask.
module status_reg #(
  parameter logic RESET_I    = 1'b1,
  parameter logic BIT5_VALUE = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_alu_valid,
  input  logic       i_alu_n,
  input  logic       i_alu_v,
  input  logic       i_alu_z,
  input  logic       i_alu_c,
  input  logic [3:0] i_flag_we,
  input  logic [2:0] i_flag_op,
  input  logic       i_p_load,
  input  logic [7:0] i_p_din,
  input  logic       i_brk_push,
  input  logic       i_instr_end,
  output logic [7:0] o_p_out,
  output logic       o_carry,
  output logic       o_dec,
  output logic       o_irq_mask
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_SEC = 3'd1;
  localparam logic [2:0] OP_CLC = 3'd2;
  localparam logic [2:0] OP_SEI = 3'd3;
  localparam logic [2:0] OP_CLI = 3'd4;
  localparam logic [2:0] OP_SED = 3'd5;
  localparam logic [2:0] OP_CLD = 3'd6;
  localparam logic [2:0] OP_CLV = 3'd7;

  logic r_n, r_v, r_d, r_i, r_z, r_c, r_irq_mask;
  logic w_n, w_v, w_d, w_i, w_z, w_c;

  // Flag instruction is applied after the ALU capture so it wins on the same flag.
  always_comb begin
    w_n = r_n;
    w_v = r_v;
    w_d = r_d;
    w_i = r_i;
    w_z = r_z;
    w_c = r_c;
    if (i_p_load) begin
      w_n = i_p_din[7];
      w_v = i_p_din[6];
      w_d = i_p_din[3];
      w_i = i_p_din[2];
      w_z = i_p_din[1];
      w_c = i_p_din[0];
    end else begin
      if (i_alu_valid) begin
        if (i_flag_we[3]) w_n = i_alu_n;
        if (i_flag_we[2]) w_v = i_alu_v;
        if (i_flag_we[1]) w_z = i_alu_z;
        if (i_flag_we[0]) w_c = i_alu_c;
      end
      case (i_flag_op)
        OP_NOP:  ;
        OP_SEC:  w_c = 1'b1;
        OP_CLC:  w_c = 1'b0;
        OP_SEI:  w_i = 1'b1;
        OP_CLI:  w_i = 1'b0;
        OP_SED:  w_d = 1'b1;
        OP_CLD:  w_d = 1'b0;
        OP_CLV:  w_v = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_n        <= 1'b0;
      r_v        <= 1'b0;
      r_d        <= 1'b0;
      r_i        <= RESET_I;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
      r_irq_mask <= RESET_I;
    end else begin
      r_n <= w_n;
      r_v <= w_v;
      r_d <= w_d;
      r_i <= w_i;
      r_z <= w_z;
      r_c <= w_c;
      // The mask follows I only at instruction boundaries, using the post-update value.
      if (i_instr_end) r_irq_mask <= w_i;
    end
  end

  assign o_p_out    = {r_n, r_v, BIT5_VALUE, i_brk_push, r_d, r_i, r_z, r_c};
  assign o_carry    = r_c;
  assign o_dec      = r_d;
  assign o_irq_mask = r_irq_mask;

endmodule

// File: tb/tb_status_reg.sv
// Directed bench for status_reg with hand-computed expected values.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alu_valid, alu_n, alu_v, alu_z, alu_c;
  logic [3:0] flag_we;
  logic [2:0] flag_op;
  logic       p_load;
  logic [7:0] p_din;
  logic       brk_push;
  logic       instr_end;
  logic [7:0] p_out;
  logic       carry, dec, irq_mask;

  int n_tests = 0;
  int n_fail  = 0;

  status_reg #(.RESET_I(1'b1), .BIT5_VALUE(1'b1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_alu_valid (alu_valid),
    .i_alu_n     (alu_n),
    .i_alu_v     (alu_v),
    .i_alu_z     (alu_z),
    .i_alu_c     (alu_c),
    .i_flag_we   (flag_we),
    .i_flag_op   (flag_op),
    .i_p_load    (p_load),
    .i_p_din     (p_din),
    .i_brk_push  (brk_push),
    .i_instr_end (instr_end),
    .o_p_out     (p_out),
    .o_carry     (carry),
    .o_dec       (dec),
    .o_irq_mask  (irq_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_n = 0; alu_v = 0; alu_z = 0; alu_c = 0;
    flag_we = 4'h0; flag_op = 3'd0; p_load = 0; p_din = 8'h00;
    brk_push = 0; instr_end = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    // Async reset before any clock edge
    #3 rst = 1'b1;
    #1;
    check("rst_p_out", p_out, 8'h24);
    check("rst_carry", {7'd0, carry}, 8'h00);
    check("rst_dec",   {7'd0, dec}, 8'h00);
    check("rst_irq",   {7'd0, irq_mask}, 8'h01);
    #8 rst = 1'b0;
    step();
    check("post_rst_p_out", p_out, 8'h24);

    // ALU capture N,Z,C (V not enabled)
    alu_valid = 1; flag_we = 4'b1011; alu_n = 1; alu_v = 1; alu_z = 1; alu_c = 1;
    step();
    check("alu_cap_p_out", p_out, 8'hA7);
    check("alu_cap_carry", {7'd0, carry}, 8'h01);

    // alu_valid=0 ignores flag_we
    alu_valid = 0; flag_we = 4'hF; alu_n = 0; alu_v = 1; alu_z = 0; alu_c = 0;
    step();
    check("alu_invalid_hold", p_out, 8'hA7);

    // p_load beats flag_op and ALU capture
    idle();
    p_load = 1; p_din = 8'hC3; flag_op = 3'd1; alu_valid = 1; flag_we = 4'hF; brk_push = 1;
    step();
    check("prio_p_out", p_out, 8'hF3);
    check("prio_irq_hold", {7'd0, irq_mask}, 8'h01);

    // CLC beats ALU carry; ALU still writes N
    idle();
    flag_op = 3'd2; alu_valid = 1; flag_we = 4'b1001; alu_c = 1; alu_n = 0;
    step();
    check("clc_conflict_carry", {7'd0, carry}, 8'h00);
    check("clc_conflict_p_out", p_out, 8'h62);

    // CLV beats ALU overflow
    idle();
    flag_op = 3'd7; alu_valid = 1; flag_we = 4'b0100; alu_v = 1;
    step();
    check("clv_conflict_p_out", p_out, 8'h22);

    // All-zero flag_we with alu_valid is a no-op
    idle();
    alu_valid = 1; alu_n = 1; alu_v = 1; alu_z = 0; alu_c = 1;
    step();
    check("we_zero_noop", p_out, 8'h22);

    // SEI at instruction end: mask follows the new I
    idle();
    flag_op = 3'd3; instr_end = 1;
    step();
    check("sei_end_irq", {7'd0, irq_mask}, 8'h01);
    check("sei_end_p_out", p_out, 8'h26);

    // CLI mid-instruction: I clears, mask holds
    idle();
    flag_op = 3'd4;
    step();
    check("cli_mid_i", {7'd0, p_out[2]}, 8'h00);
    check("cli_mid_irq", {7'd0, irq_mask}, 8'h01);
    idle();
    step();
    check("cli_mid_irq_hold", {7'd0, irq_mask}, 8'h01);
    instr_end = 1;
    step();
    check("cli_end_irq", {7'd0, irq_mask}, 8'h00);

    // PLP with instr_end: mask takes p_din[2]
    idle();
    p_load = 1; p_din = 8'h04; instr_end = 1;
    step();
    check("plp_irq", {7'd0, irq_mask}, 8'h01);
    check("plp_p_out", p_out, 8'h24);

    // CLI together with instr_end: mask updates at that boundary
    idle();
    flag_op = 3'd4; instr_end = 1;
    step();
    check("cli_same_end_irq", {7'd0, irq_mask}, 8'h00);

    // Push image with D,I,C set
    idle();
    p_load = 1; p_din = 8'h0D;
    step();
    idle();
    brk_push = 1;
    #1;
    check("push_brk1", p_out, 8'h3D);
    brk_push = 0;
    #1;
    check("push_brk0", p_out, 8'h2D);
    check("dec_set", {7'd0, dec}, 8'h01);

    // CLD / SED
    flag_op = 3'd6;
    step();
    check("cld_dec", {7'd0, dec}, 8'h00);
    flag_op = 3'd5;
    step();
    check("sed_dec", {7'd0, dec}, 8'h01);

    // p_din[5:4] ignored on load
    idle();
    p_load = 1; p_din = 8'h30;
    step();
    check("load_bit54_ignored", p_out, 8'h20);

    // Mid-instruction reset discards a pending load
    idle();
    p_load = 1; p_din = 8'hFF; instr_end = 1;
    #2 rst = 1'b1;
    #1;
    check("midrst_p_out", p_out, 8'h24);
    step();
    check("midrst_hold_p_out", p_out, 8'h24);
    check("midrst_irq", {7'd0, irq_mask}, 8'h01);
    idle();
    #2 rst = 1'b0;
    step();
    check("after_midrst_p_out", p_out, 8'h24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
